// File: rtl/cam_mode_ctrl.sv
// Frame-synchronous mode controller between the mode selector and the OV7670 capture path.
// Reprograms the camera over SCCB on format/test-mode changes and gates capture until frames settle.
module cam_mode_ctrl #(
  parameter int c_to_w        = 24,
  parameter int c_retries     = 3,
  parameter int c_skip_frames = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rgbmode_req,
  input  logic       testmode_req,
  input  logic [2:0] rgbfilter_req,
  input  logic       vsync,
  input  logic       sccb_ready,
  input  logic       sccb_done,
  output logic       cfg_start,
  output logic       cfg_rgbmode,
  output logic       cfg_testmode,
  output logic       capture_en,
  output logic [2:0] rgbfilter_act,
  output logic       busy,
  output logic       cfg_err
);

  // state | meaning
  // INIT  | latch requested mode, clear retries
  // START | wait for SCCB master idle, fire start
  // WAIT  | wait for sequence done or timeout
  // SKIP  | discard frames while the sensor settles
  // RUN   | capturing, watch for changes at frame ends
  typedef enum logic [2:0] {S_INIT, S_START, S_WAIT, S_SKIP, S_RUN} state_t;

  localparam int c_rt_w = $clog2(c_retries + 2);
  localparam int c_sk_w = $clog2(c_skip_frames + 2);

  state_t              state, state_nxt;
  logic                vsync_q, vsync_qq;
  logic [c_to_w-1:0]   to_cnt;
  logic [c_rt_w-1:0]   rt_cnt;
  logic [c_sk_w-1:0]   sk_cnt;
  logic                fe, mode_diff, to_zero, rt_max, sk_last;

  // vsync is registered once more so a frame edge acts two cycles after the rise
  assign fe        = vsync_q & ~vsync_qq;
  assign mode_diff = {rgbmode_req, testmode_req} != {cfg_rgbmode, cfg_testmode};
  assign to_zero   = (to_cnt == '0);
  assign rt_max    = (rt_cnt == c_rt_w'(c_retries));
  assign sk_last   = (sk_cnt == c_sk_w'(c_skip_frames));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  state_nxt = S_START;
      S_START: if (sccb_ready) state_nxt = S_WAIT;
      S_WAIT: begin
        if (sccb_done)    state_nxt = S_SKIP;
        else if (to_zero) state_nxt = rt_max ? S_SKIP : S_START;
      end
      S_SKIP:  if (fe && sk_last) state_nxt = S_RUN;
      S_RUN:   if (fe && mode_diff) state_nxt = S_START;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    busy = (state != S_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsync_q       <= 1'b0;
      vsync_qq      <= 1'b0;
      cfg_start     <= 1'b0;
      cfg_rgbmode   <= 1'b1;
      cfg_testmode  <= 1'b0;
      capture_en    <= 1'b0;
      rgbfilter_act <= 3'b000;
      cfg_err       <= 1'b0;
      to_cnt        <= '0;
      rt_cnt        <= '0;
      sk_cnt        <= '0;
    end else begin
      vsync_q   <= vsync;
      vsync_qq  <= vsync_q;
      cfg_start <= 1'b0;
      case (state)
        S_INIT: begin
          cfg_rgbmode  <= rgbmode_req;
          cfg_testmode <= testmode_req;
          rt_cnt       <= '0;
        end
        S_START: begin
          if (sccb_ready) begin
            cfg_start <= 1'b1;
            to_cnt    <= '1;
          end
        end
        S_WAIT: begin
          if (sccb_done) begin
            sk_cnt <= '0;
          end else if (to_zero) begin
            // on the error path SKIP still needs a clean frame count
            if (rt_max) begin
              cfg_err <= 1'b1;
              sk_cnt  <= '0;
            end else begin
              rt_cnt <= rt_cnt + c_rt_w'(1);
            end
          end else begin
            to_cnt <= to_cnt - c_to_w'(1);
          end
        end
        S_SKIP: begin
          if (fe) begin
            sk_cnt <= sk_cnt + c_sk_w'(1);
            if (sk_last) begin
              capture_en    <= 1'b1;
              rgbfilter_act <= rgbfilter_req;
            end
          end
        end
        S_RUN: begin
          if (fe) begin
            if (mode_diff) begin
              capture_en   <= 1'b0;
              cfg_rgbmode  <= rgbmode_req;
              cfg_testmode <= testmode_req;
              rt_cnt       <= '0;
            end else begin
              rgbfilter_act <= rgbfilter_req;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_mode_ctrl.sv
// Directed bench for cam_mode_ctrl: main instance for sequencing/filter/mode tests,
// a second instance with a short timeout for the retry and expiry corner cases.
module tb_cam_mode_ctrl;

  logic       clk, rst, rst_to;
  logic       rgbmode_req, testmode_req, vsync, sccb_ready, sccb_done, done_to;
  logic [2:0] rgbfilter_req;

  logic       cfg_start, cfg_rgbmode, cfg_testmode, capture_en, busy, cfg_err;
  logic [2:0] rgbfilter_act;
  logic       cfg_start_to, cfg_rgbmode_to, cfg_testmode_to, capture_en_to, busy_to, cfg_err_to;
  logic [2:0] rgbfilter_act_to;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;

  cam_mode_ctrl #(.c_to_w(8), .c_retries(3), .c_skip_frames(2)) dut (
    .clk(clk), .rst(rst), .rgbmode_req(rgbmode_req), .testmode_req(testmode_req),
    .rgbfilter_req(rgbfilter_req), .vsync(vsync), .sccb_ready(sccb_ready), .sccb_done(sccb_done),
    .cfg_start(cfg_start), .cfg_rgbmode(cfg_rgbmode), .cfg_testmode(cfg_testmode),
    .capture_en(capture_en), .rgbfilter_act(rgbfilter_act), .busy(busy), .cfg_err(cfg_err)
  );

  cam_mode_ctrl #(.c_to_w(4), .c_retries(3), .c_skip_frames(2)) dut_to (
    .clk(clk), .rst(rst_to), .rgbmode_req(rgbmode_req), .testmode_req(testmode_req),
    .rgbfilter_req(rgbfilter_req), .vsync(vsync), .sccb_ready(sccb_ready), .sccb_done(done_to),
    .cfg_start(cfg_start_to), .cfg_rgbmode(cfg_rgbmode_to), .cfg_testmode(cfg_testmode_to),
    .capture_en(capture_en_to), .rgbfilter_act(rgbfilter_act_to), .busy(busy_to), .cfg_err(cfg_err_to)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (cfg_start) start_cnt <= start_cnt + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0] filt;
    logic [2:0] exp_act;
    logic       exp_cap;
  } fvec_t;
  fvec_t fv[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rise();
    vsync = 1'b1;
    tick();
    tick();
  endtask

  task automatic fall();
    repeat (3) tick();
    vsync = 1'b0;
    repeat (5) tick();
  endtask

  task automatic wait_start(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cfg_start) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  task automatic wait_start_to(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cfg_start_to) begin
        found = 1'b1;
        break;
      end
    end
    check(name, found, 1);
  endtask

  // After a reconfiguration has been triggered: finish SCCB, end the frame, then three frame edges.
  task automatic reconfig_run(input string name, input logic [2:0] act_mid, input logic [2:0] act_fin);
    wait_start({name, "_start"});
    repeat (5) tick();
    sccb_done = 1'b1;
    tick();
    sccb_done = 1'b0;
    fall();
    for (int f = 0; f < 3; f++) begin
      rise();
      if (f < 2) begin
        check({name, "_skip_cap"}, capture_en, 0);
        check({name, "_skip_act"}, rgbfilter_act, act_mid);
      end else begin
        check({name, "_run_cap"}, capture_en, 1);
        check({name, "_run_busy"}, busy, 0);
        check({name, "_run_act"}, rgbfilter_act, act_fin);
      end
      fall();
    end
  endtask

  initial begin
    int s0;
    int n;
    int ts[8];
    logic err_at4;
    logic [2:0] prev_act;

    fv[0] = '{3'b100, 3'b100, 1'b1};
    fv[1] = '{3'b010, 3'b010, 1'b1};
    fv[2] = '{3'b010, 3'b010, 1'b1};
    fv[3] = '{3'b111, 3'b111, 1'b1};
    fv[4] = '{3'b001, 3'b001, 1'b1};
    fv[5] = '{3'b000, 3'b000, 1'b1};

    rst = 1'b0; rst_to = 1'b0;
    rgbmode_req = 1'b1; testmode_req = 1'b0; rgbfilter_req = 3'b000;
    vsync = 1'b0; sccb_ready = 1'b1; sccb_done = 1'b0; done_to = 1'b0;
    repeat (3) tick();

    check("rst_cfg_start", cfg_start, 0);
    check("rst_cfg_rgbmode", cfg_rgbmode, 1);
    check("rst_cfg_testmode", cfg_testmode, 0);
    check("rst_capture_en", capture_en, 0);
    check("rst_rgbfilter_act", rgbfilter_act, 0);
    check("rst_busy", busy, 1);
    check("rst_cfg_err", cfg_err, 0);

    // power-up
    rst = 1'b1;
    wait_start("pu_start");
    repeat (49) tick();
    sccb_done = 1'b1;
    tick();
    sccb_done = 1'b0;
    tick();
    check("pu_busy_skip", busy, 1);
    for (int f = 0; f < 3; f++) begin
      check("pu_cap_before_edge", capture_en, 0);
      rise();
      if (f < 2) check("pu_cap_skip", capture_en, 0);
      else begin
        check("pu_cap_run", capture_en, 1);
        check("pu_busy_run", busy, 0);
      end
      fall();
      if (f == 0) begin
        // a stray done while skipping must not restart the frame count
        sccb_done = 1'b1;
        tick();
        sccb_done = 1'b0;
      end
    end
    check("pu_start_cnt", start_cnt, 1);
    check("pu_cfg_err", cfg_err, 0);

    // filter-only changes in RUN
    prev_act = 3'b000;
    for (int i = 0; i < 6; i++) begin
      rgbfilter_req = fv[i].filt;
      tick();
      check("flt_hold", rgbfilter_act, prev_act);
      rise();
      check("flt_act", rgbfilter_act, fv[i].exp_act);
      check("flt_cap", capture_en, fv[i].exp_cap);
      check("flt_busy", busy, 0);
      prev_act = fv[i].exp_act;
      fall();
    end
    check("flt_start_cnt", start_cnt, 1);

    // mode change
    s0 = start_cnt;
    rgbmode_req = 1'b0;
    tick();
    check("mode_pre_cap", capture_en, 1);
    check("mode_pre_cfg", cfg_rgbmode, 1);
    rise();
    check("mode_cap_off", capture_en, 0);
    check("mode_cfg_rgb", cfg_rgbmode, 0);
    check("mode_busy", busy, 1);
    reconfig_run("mode", 3'b000, 3'b000);
    check("mode_start_cnt", start_cnt, s0 + 1);

    // mode and filter change on the same frame edge
    s0 = start_cnt;
    testmode_req = 1'b1;
    rgbfilter_req = 3'b011;
    tick();
    rise();
    check("sim_cap_off", capture_en, 0);
    check("sim_act_held", rgbfilter_act, 3'b000);
    check("sim_cfg_test", cfg_testmode, 1);
    reconfig_run("sim", 3'b000, 3'b011);
    check("sim_start_cnt", start_cnt, s0 + 1);

    // asynchronous reset while waiting for SCCB
    s0 = start_cnt;
    testmode_req = 1'b0;
    tick();
    rise();
    wait_start("ar_first_start");
    repeat (3) tick();
    #3 rst = 1'b0;
    #1;
    check("ar_cfg_rgbmode", cfg_rgbmode, 1);
    check("ar_rgbfilter_act", rgbfilter_act, 0);
    check("ar_capture_en", capture_en, 0);
    check("ar_busy", busy, 1);
    check("ar_cfg_start", cfg_start, 0);
    check("ar_cfg_err", cfg_err, 0);
    tick();
    rst = 1'b1;
    reconfig_run("ar", 3'b000, 3'b011);
    check("ar_cfg_latched", {cfg_rgbmode, cfg_testmode}, 2'b00);
    check("ar_start_cnt", start_cnt, s0 + 2);

    // timeout and retries on the short-timeout instance
    rst_to = 1'b1;
    n = 0;
    err_at4 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (cfg_start_to && n < 8) begin
        ts[n] = i;
        n++;
        if (n == 4) err_at4 = cfg_err_to;
      end
    end
    check("to_pulses", n, 4);
    for (int k = 0; k < 3; k++) check("to_spacing", ts[k+1] - ts[k], 17);
    check("to_err_not_early", err_at4, 0);
    check("to_err_set", cfg_err_to, 1);
    check("to_busy_skip", busy_to, 1);
    for (int f = 0; f < 3; f++) begin
      rise();
      if (f < 2) check("to_skip_cap", capture_en_to, 0);
      else begin
        check("to_run_cap", capture_en_to, 1);
        check("to_run_busy", busy_to, 0);
      end
      fall();
    end
    check("to_err_sticky", cfg_err_to, 1);

    // done arriving on the timeout-expiry cycle
    rst_to = 1'b0;
    tick();
    check("exp_err_cleared", cfg_err_to, 0);
    rst_to = 1'b1;
    wait_start_to("exp_start");
    repeat (15) tick();
    done_to = 1'b1;
    tick();
    done_to = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (cfg_start_to) n++;
    end
    check("exp_no_retry", n, 0);
    check("exp_busy_skip", busy_to, 1);
    for (int f = 0; f < 3; f++) begin
      rise();
      if (f == 2) check("exp_run_cap", capture_en_to, 1);
      fall();
    end
    check("exp_err", cfg_err_to, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
